// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: classifies high pulses as bits, assembles LSB-first words,
// detects the latch gap that ends a frame and flags malformed pulses or partial words.
module ws2812_rx #(
    parameter int unsigned F_CLK    = 12_000_000,
    parameter int unsigned BITWIDTH = 24,
    parameter int unsigned THRESH   = 525 * (F_CLK / 1000) / 1_000_000,
    parameter int unsigned TMAXHIGH = 1250 * (F_CLK / 1000) / 1_000_000,
    parameter int unsigned TRESET   = 50 * (F_CLK / 1000) / 1000
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                Ws2812In,
    output logic [BITWIDTH-1:0] Data,
    output logic                Valid,
    output logic                Latch,
    output logic                Error,
    output logic [7:0]          WordCount
);

    localparam int unsigned CW  = $clog2(TRESET + 1);
    localparam int unsigned BCW = $clog2(BITWIDTH);

    localparam logic [CW-1:0]  C_ONE      = CW'(1);
    localparam logic [CW-1:0]  C_THRESH   = CW'(THRESH);
    localparam logic [CW-1:0]  C_TMAX     = CW'(TMAXHIGH);
    localparam logic [CW-1:0]  C_TRESET   = CW'(TRESET);
    localparam logic [CW-1:0]  C_TRESETM1 = CW'(TRESET - 1);
    localparam logic [BCW-1:0] C_BITLAST  = BCW'(BITWIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StHigh,
        StLow,
        StLatched,
        StWaitLow
    } state_e;

    state_e                r_state;
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_prev;
    logic [CW-1:0]         r_cnt;
    logic [BCW-1:0]        r_bitcnt;
    // One bit narrower than a word: the final bit goes straight into Data.
    logic [BITWIDTH-2:0]   r_shift;
    logic [BITWIDTH-1:0]   r_data;
    logic                  r_valid;
    logic                  r_latch;
    logic                  r_error;
    logic [7:0]            r_wcount;

    logic w_rise;
    logic w_fall;
    logic w_bit;

    assign w_rise = r_sync2 & ~r_prev;
    assign w_fall = ~r_sync2 & r_prev;
    assign w_bit  = (r_cnt >= C_THRESH);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= Ws2812In;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_latch  <= 1'b0;
            r_error  <= 1'b0;
            r_wcount <= '0;
        end else begin
            r_valid <= 1'b0;
            r_latch <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_rise) begin
                        r_cnt   <= C_ONE;
                        r_state <= StHigh;
                    end
                end
                StHigh: begin
                    if (w_fall) begin
                        r_cnt   <= C_ONE;
                        r_state <= StLow;
                        if (r_bitcnt == C_BITLAST) begin
                            r_data   <= {w_bit, r_shift};
                            r_valid  <= 1'b1;
                            r_bitcnt <= '0;
                            r_shift  <= '0;
                            if (r_wcount != 8'hFF) begin
                                r_wcount <= r_wcount + 8'd1;
                            end
                        end else begin
                            r_shift  <= {w_bit, r_shift[BITWIDTH-2:1]};
                            r_bitcnt <= r_bitcnt + 1'b1;
                        end
                    end else if (r_cnt >= C_TMAX) begin
                        // Still high with the count about to pass TMAXHIGH.
                        r_error  <= 1'b1;
                        r_bitcnt <= '0;
                        r_shift  <= '0;
                        r_cnt    <= '0;
                        r_state  <= StWaitLow;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StLow: begin
                    if (w_rise) begin
                        r_cnt   <= C_ONE;
                        r_state <= StHigh;
                    end else if (r_cnt >= C_TRESETM1) begin
                        r_cnt   <= C_TRESET;
                        r_latch <= 1'b1;
                        r_state <= StLatched;
                        if (r_bitcnt != '0) begin
                            r_error  <= 1'b1;
                            r_bitcnt <= '0;
                            r_shift  <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StLatched: begin
                    r_wcount <= '0;
                    r_cnt    <= '0;
                    r_state  <= StIdle;
                end
                StWaitLow: begin
                    if (r_sync2) begin
                        r_cnt <= '0;
                    end else if (r_cnt >= C_TRESETM1) begin
                        r_cnt    <= '0;
                        r_wcount <= '0;
                        r_state  <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign Data      = r_data;
    assign Valid     = r_valid;
    assign Latch     = r_latch;
    assign Error     = r_error;
    assign WordCount = r_wcount;

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: drives WS2812 pulse trains and compares observed events against
// words, latch and error timing derived from the bit stream sent.
module tb_ws2812_rx;

    localparam int BW       = 24;
    localparam int THRESH   = 6;
    localparam int TMAXHIGH = 15;
    localparam int TRESET   = 600;
    localparam int GAP      = 720;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          pin   = 1'b0;
    logic [BW-1:0] data;
    logic          valid;
    logic          latch;
    logic          error;
    logic [7:0]    wcount;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic          bit_q[$];
    int            fall_q[$];
    logic [BW-1:0] q_vdata[$];
    int            q_vcyc[$];
    int            q_lcyc[$];
    int            q_lwc[$];
    int            q_wca[$];
    int            q_ecyc[$];
    logic          l_prev = 1'b0;

    ws2812_rx dut (
        .Clk      (clk),
        .Reset_n  (rst_n),
        .Ws2812In (pin),
        .Data     (data),
        .Valid    (valid),
        .Latch    (latch),
        .Error    (error),
        .WordCount(wcount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) begin
                q_vdata.push_back(data);
                q_vcyc.push_back(cyc);
            end
            if (latch) begin
                q_lcyc.push_back(cyc);
                q_lwc.push_back(int'(wcount));
            end
            if (l_prev) q_wca.push_back(int'(wcount));
            if (error) q_ecyc.push_back(cyc);
        end
        l_prev <= latch;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_ev();
        bit_q.delete();
        fall_q.delete();
        q_vdata.delete();
        q_vcyc.delete();
        q_lcyc.delete();
        q_lwc.delete();
        q_wca.delete();
        q_ecyc.delete();
    endtask

    task automatic push_word(input logic [BW-1:0] w, input int nbits);
        for (int b = 0; b < nbits; b++) bit_q.push_back(w[b]);
    endtask

    // mode 0: random legal timing, 1: T0H4/T0L9 T1H8/T1L7, 2: high 5 vs 6 at threshold
    task automatic send_frame(input int mode, input bit gap);
        int h;
        int l;
        for (int i = 0; i < bit_q.size(); i++) begin
            case (mode)
                1: begin
                    h = bit_q[i] ? 8 : 4;
                    l = bit_q[i] ? 7 : 9;
                end
                2: begin
                    h = bit_q[i] ? THRESH : THRESH - 1;
                    l = 6;
                end
                default: begin
                    h = bit_q[i] ? int'($urandom_range(TMAXHIGH, THRESH))
                                 : int'($urandom_range(THRESH - 1, 1));
                    l = int'($urandom_range(10, 3));
                end
            endcase
            pin = 1'b1;
            repeat (h) @(posedge clk);
            #1;
            pin = 1'b0;
            fall_q.push_back(cyc);
            if (i == bit_q.size() - 1) l = gap ? GAP : 5;
            repeat (l) @(posedge clk);
            #1;
        end
    endtask

    task automatic check_frame(input string tag);
        int            nfull;
        bit            partial;
        int            last_fall;
        logic [BW-1:0] w;
        nfull     = bit_q.size() / BW;
        partial   = (bit_q.size() % BW) != 0;
        last_fall = fall_q[fall_q.size() - 1];
        w         = '0;
        chk({tag, "_nvalid"}, 32'(q_vdata.size()), 32'(nfull));
        for (int k = 0; k < nfull && k < q_vdata.size(); k++) begin
            w = '0;
            for (int b = 0; b < BW; b++) w[b] = bit_q[k * BW + b];
            chk({tag, "_data"}, 32'(q_vdata[k]), 32'(w));
            chk({tag, "_vcyc"}, 32'(q_vcyc[k]), 32'(fall_q[k * BW + BW - 1] + 3));
        end
        if (nfull > 0) chk({tag, "_hold"}, 32'(data), 32'(w));
        chk({tag, "_nlatch"}, 32'(q_lcyc.size()), 32'd1);
        if (q_lcyc.size() > 0) begin
            chk({tag, "_lcyc"}, 32'(q_lcyc[0]), 32'(last_fall + 2 + TRESET));
            chk({tag, "_lwc"}, 32'(q_lwc[0]), 32'(nfull > 255 ? 255 : nfull));
        end
        if (q_wca.size() > 0) chk({tag, "_wc_after"}, 32'(q_wca[0]), 32'd0);
        chk({tag, "_nerr"}, 32'(q_ecyc.size()), partial ? 32'd1 : 32'd0);
        if (partial && q_ecyc.size() > 0) begin
            chk({tag, "_ecyc"}, 32'(q_ecyc[0]), 32'(last_fall + 2 + TRESET));
        end
    endtask

    initial begin
        int            c_r;
        int            nw;
        logic [BW-1:0] rw;

        // Outputs stay zero while reset is held and the line toggles.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            pin = ~pin;
            @(negedge clk);
            chk("rst_data", 32'(data), 32'd0);
            chk("rst_flags", 32'({valid, latch, error, wcount}), 32'd0);
        end
        @(posedge clk);
        #1;
        pin = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        pin = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("rel_nvalid", 32'(q_vdata.size()), 32'd0);
        chk("rel_nerr", 32'(q_ecyc.size()), 32'd0);
        chk("rel_wcount", 32'(wcount), 32'd0);

        clear_ev();
        push_word(24'hA53C0F, BW);
        send_frame(1, 1'b1);
        check_frame("single");

        clear_ev();
        push_word(24'h000000, BW);
        push_word(24'hFFFFFF, BW);
        push_word(24'h800001, BW);
        send_frame(0, 1'b1);
        check_frame("b2b");

        clear_ev();
        push_word(24'hAAAAAA, BW);
        send_frame(2, 1'b1);
        check_frame("thr_aa");

        clear_ev();
        push_word(24'h555555, BW);
        send_frame(2, 1'b1);
        check_frame("thr_55");

        for (int r = 0; r < 2; r++) begin
            clear_ev();
            nw = int'($urandom_range(3, 1));
            for (int k = 0; k < nw; k++) begin
                rw = BW'($urandom);
                push_word(rw, BW);
            end
            send_frame(0, 1'b1);
            check_frame("rand");
        end

        clear_ev();
        rw = BW'($urandom);
        push_word(rw, 10);
        send_frame(0, 1'b1);
        check_frame("partial");

        // Overlong high pulse: error 18 cycles after pin rise, no latch after the gap.
        clear_ev();
        pin = 1'b1;
        c_r = cyc;
        repeat (20) @(posedge clk);
        #1;
        pin = 1'b0;
        repeat (GAP) @(posedge clk);
        #1;
        chk("long_nerr", 32'(q_ecyc.size()), 32'd1);
        if (q_ecyc.size() > 0) chk("long_ecyc", 32'(q_ecyc[0]), 32'(c_r + 18));
        chk("long_nlatch", 32'(q_lcyc.size()), 32'd0);
        chk("long_nvalid", 32'(q_vdata.size()), 32'd0);

        clear_ev();
        rw = BW'($urandom);
        push_word(rw, BW);
        send_frame(0, 1'b1);
        check_frame("after_err");

        clear_ev();
        rw = BW'($urandom);
        push_word(rw, 12);
        send_frame(0, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midrst_data", 32'(data), 32'd0);
        chk("midrst_flags", 32'({valid, latch, error, wcount}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_nev", 32'(q_vdata.size() + q_ecyc.size() + q_lcyc.size()), 32'd0);

        clear_ev();
        push_word(24'h123456, BW);
        send_frame(0, 1'b1);
        check_frame("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
